// File: rtl/hdmi_sched_pkg.sv
// rtl/hdmi_sched_pkg.sv - mode/preamble encodings, period lengths and island FSM state type
package hdmi_sched_pkg;

  localparam logic [2:0] MODE_CTRL   = 3'd0;
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_VGUARD = 3'd2;
  localparam logic [2:0] MODE_ISLAND = 3'd3;
  localparam logic [2:0] MODE_IGUARD = 3'd4;

  // Preamble codes packed as {ctl2, ctl1}
  localparam logic [3:0] PRE_VIDEO  = 4'b0001;
  localparam logic [3:0] PRE_ISLAND = 4'b0101;

  localparam int PREAMBLE_LEN  = 8;
  localparam int GUARD_LEN     = 2;
  localparam int PACKET_LEN    = 32;
  localparam int MIN_CTRL_TAIL = 14;

  typedef enum logic [2:0] {
    DI_IDLE,
    DI_PREAMBLE,
    DI_LEAD_GUARD,
    DI_PACKET,
    DI_TRAIL_GUARD
  } di_state_t;

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// rtl/hdmi_period_scheduler_if.sv - scheduler outputs to the TMDS encoders plus packet slot handshake
interface hdmi_period_scheduler_if;
  logic        packet_valid;
  logic        packet_ready;
  logic [11:0] cx;
  logic [10:0] cy;
  logic [2:0]  mode;
  logic [1:0]  ctl0;
  logic [1:0]  ctl1;
  logic [1:0]  ctl2;
  logic [4:0]  di_index;
  logic        di_first;
  logic        frame_start;

  modport master (
    input  packet_valid,
    output packet_ready, cx, cy, mode, ctl0, ctl1, ctl2, di_index, di_first, frame_start
  );

  modport slave (
    output packet_valid,
    input  packet_ready, cx, cy, mode, ctl0, ctl1, ctl2, di_index, di_first, frame_start
  );
endinterface

// File: rtl/hdmi_timing_counter.sv
// rtl/hdmi_timing_counter.sv - raster position, sync levels and frame_start; exposes next position
module hdmi_timing_counter #(
  parameter int H_ACTIVE  = 1920,
  parameter int H_FRONT   = 88,
  parameter int H_SYNC    = 44,
  parameter int H_BACK    = 148,
  parameter int V_ACTIVE  = 1080,
  parameter int V_FRONT   = 4,
  parameter int V_SYNC    = 5,
  parameter int V_BACK    = 36,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        clk_pixel,
  input  logic        reset,
  output logic [11:0] cx,
  output logic [10:0] cy,
  output logic [11:0] nx_cx,
  output logic [10:0] nx_cy,
  output logic [1:0]  ctl0,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  logic last_x, last_y, hs_on, vs_on;

  assign last_x = (cx == 12'(H_TOTAL - 1));
  assign last_y = (cy == 11'(V_TOTAL - 1));
  assign nx_cx  = last_x ? 12'd0 : cx + 12'd1;
  assign nx_cy  = last_x ? (last_y ? 11'd0 : cy + 11'd1) : cy;

  // Sync decoded on the next position so it lands aligned with cx/cy
  assign hs_on = (nx_cx >= 12'(H_ACTIVE + H_FRONT)) && (nx_cx < 12'(H_ACTIVE + H_FRONT + H_SYNC));
  assign vs_on = (nx_cy >= 11'(V_ACTIVE + V_FRONT)) && (nx_cy < 11'(V_ACTIVE + V_FRONT + V_SYNC));

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cx          <= 12'd0;
      cy          <= 11'd0;
      ctl0        <= {~VSYNC_POL, ~HSYNC_POL};
      frame_start <= 1'b0;
    end else begin
      cx          <= nx_cx;
      cy          <= nx_cy;
      ctl0        <= {vs_on ? VSYNC_POL : ~VSYNC_POL, hs_on ? HSYNC_POL : ~HSYNC_POL};
      frame_start <= last_x && last_y;
    end
  end
endmodule

// File: rtl/hdmi_period_scheduler.sv
// rtl/hdmi_period_scheduler.sv - per-pixel HDMI period sequencing; data islands built only with HDMI_DATA_ISLAND_EN
module hdmi_period_scheduler
  import hdmi_sched_pkg::*;
#(
  parameter int H_ACTIVE    = 1920,
  parameter int H_FRONT     = 88,
  parameter int H_SYNC      = 44,
  parameter int H_BACK      = 148,
  parameter int V_ACTIVE    = 1080,
  parameter int V_FRONT     = 4,
  parameter int V_SYNC      = 5,
  parameter int V_BACK      = 36,
  parameter bit HSYNC_POL   = 1'b1,
  parameter bit VSYNC_POL   = 1'b1,
  parameter int MAX_PACKETS = 2
) (
  input logic                     clk_pixel,
  input logic                     reset,
  hdmi_period_scheduler_if.master bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DI_START = H_ACTIVE + 4;

  if (MAX_PACKETS < 1 || MAX_PACKETS > 18) begin : g_bad_max_packets
    $error("MAX_PACKETS must be within 1..18");
  end
  if (DI_START + PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN > H_TOTAL - MIN_CTRL_TAIL) begin : g_bad_fit
    $error("a one-packet data island does not fit in horizontal blanking");
  end

  logic [11:0] nx_cx;
  logic [10:0] nx_cy;
  logic        nx_video, pre_line, nx_vpre, nx_vguard;
  logic [2:0]  vid_mode, nxt_mode;
  logic [3:0]  vid_pre, nxt_pre;
  logic        nxt_ready, nxt_first;
  logic [4:0]  nxt_index;

  hdmi_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .cx          (bus.cx),
    .cy          (bus.cy),
    .nx_cx       (nx_cx),
    .nx_cy       (nx_cy),
    .ctl0        (bus.ctl0),
    .frame_start (bus.frame_start)
  );

  // Everything below is decided for the next pixel and registered alongside cx/cy
  assign nx_video  = (nx_cx < 12'(H_ACTIVE)) && (nx_cy < 11'(V_ACTIVE));
  assign pre_line  = (nx_cy < 11'(V_ACTIVE - 1)) || (nx_cy == 11'(V_TOTAL - 1));
  assign nx_vpre   = pre_line && (nx_cx >= 12'(H_TOTAL - 10)) && (nx_cx <= 12'(H_TOTAL - 3));
  assign nx_vguard = pre_line && (nx_cx >= 12'(H_TOTAL - 2));
  assign vid_mode  = nx_video ? MODE_VIDEO : (nx_vguard ? MODE_VGUARD : MODE_CTRL);
  assign vid_pre   = nx_vpre ? PRE_VIDEO : 4'b0000;

`ifdef HDMI_DATA_ISLAND_EN
  di_state_t  state, nxt_state;
  logic [4:0] cnt, nxt_cnt, pkt_count;
  logic       more_fits, start_pkt;

  // Room for another packet plus trailing guard before the mandatory control tail
  assign more_fits = int'(bus.cx) + 1 + PACKET_LEN + GUARD_LEN <= H_TOTAL - MIN_CTRL_TAIL;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 5'd1;
    case (state)
      DI_IDLE: begin
        nxt_cnt = 5'd0;
        if (nx_cx == 12'(DI_START) && bus.packet_valid) nxt_state = DI_PREAMBLE;
      end
      DI_PREAMBLE: if (cnt == 5'(PREAMBLE_LEN - 1)) begin
        nxt_state = DI_LEAD_GUARD;
        nxt_cnt   = 5'd0;
      end
      DI_LEAD_GUARD: if (cnt == 5'(GUARD_LEN - 1)) begin
        nxt_state = DI_PACKET;
        nxt_cnt   = 5'd0;
      end
      DI_PACKET: if (cnt == 5'(PACKET_LEN - 1)) begin
        nxt_cnt = 5'd0;
        if (!(bus.packet_valid && int'(pkt_count) < MAX_PACKETS && more_fits))
          nxt_state = DI_TRAIL_GUARD;
      end
      DI_TRAIL_GUARD: if (cnt == 5'(GUARD_LEN - 1)) begin
        nxt_state = DI_IDLE;
        nxt_cnt   = 5'd0;
      end
      default: begin
        nxt_state = DI_IDLE;
        nxt_cnt   = 5'd0;
      end
    endcase
  end

  assign start_pkt = (nxt_state == DI_PACKET) && (nxt_cnt == 5'd0);

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state     <= DI_IDLE;
      cnt       <= 5'd0;
      pkt_count <= 5'd0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (nx_cx == 12'd0) pkt_count <= 5'd0;
      else if (start_pkt) pkt_count <= pkt_count + 5'd1;
    end
  end

  always_comb begin
    nxt_mode = vid_mode;
    nxt_pre  = vid_pre;
    case (nxt_state)
      DI_PREAMBLE: begin
        nxt_mode = MODE_CTRL;
        nxt_pre  = PRE_ISLAND;
      end
      DI_LEAD_GUARD, DI_TRAIL_GUARD: begin
        nxt_mode = MODE_IGUARD;
        nxt_pre  = 4'b0000;
      end
      DI_PACKET: begin
        nxt_mode = MODE_ISLAND;
        nxt_pre  = 4'b0000;
      end
      default: ;
    endcase
  end

  assign nxt_ready = start_pkt;
  assign nxt_first = start_pkt && (pkt_count == 5'd0);
  assign nxt_index = (nxt_state == DI_PACKET) ? nxt_cnt : 5'd0;
`else
  logic unused_packet_valid;
  assign unused_packet_valid = bus.packet_valid;
  assign nxt_mode  = vid_mode;
  assign nxt_pre   = vid_pre;
  assign nxt_ready = 1'b0;
  assign nxt_first = 1'b0;
  assign nxt_index = 5'd0;
`endif

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      bus.mode         <= MODE_CTRL;
      bus.ctl1         <= 2'b00;
      bus.ctl2         <= 2'b00;
      bus.packet_ready <= 1'b0;
      bus.di_index     <= 5'd0;
      bus.di_first     <= 1'b0;
    end else begin
      bus.mode         <= nxt_mode;
      bus.ctl1         <= nxt_pre[1:0];
      bus.ctl2         <= nxt_pre[3:2];
      bus.packet_ready <= nxt_ready;
      bus.di_index     <= nxt_index;
      bus.di_first     <= nxt_first;
    end
  end
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb/tb_hdmi_period_scheduler.sv - directed bench for hdmi_period_scheduler; follows HDMI_DATA_ISLAND_EN
module tb_hdmi_period_scheduler;
`ifdef HDMI_DATA_ISLAND_EN
  localparam bit ISL = 1'b1;
`else
  localparam bit ISL = 1'b0;
`endif

  logic clk_pixel = 1'b0;
  logic ra, rb;
  int   total = 0, bad = 0;
  int   ka = 0, kb = 0;
  int   rdy_a = 0, rdy_b = 0, isl_a = 0, isl_b = 0, fs_a = 0;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_period_scheduler_if ia ();
  hdmi_period_scheduler_if ib ();

  // A: H_TOTAL=144, V_TOTAL=8, one packet per line
  hdmi_period_scheduler #(
    .H_ACTIVE(64), .H_FRONT(8), .H_SYNC(16), .H_BACK(56),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .MAX_PACKETS(1)
  ) dut_a (.clk_pixel(clk_pixel), .reset(ra), .bus(ia.master));

  // B: H_TOTAL=208, two packets per line
  hdmi_period_scheduler #(
    .H_ACTIVE(64), .H_FRONT(8), .H_SYNC(16), .H_BACK(120),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .MAX_PACKETS(2)
  ) dut_b (.clk_pixel(clk_pixel), .reset(rb), .bus(ib.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk_pixel);
    ka++;
    kb++;
    if (ia.mode == 3'd3 || ia.mode == 3'd4) isl_a++;
    if (ib.mode == 3'd3 || ib.mode == 3'd4) isl_b++;
    if (ia.packet_ready) rdy_a++;
    if (ib.packet_ready) rdy_b++;
    if (ia.frame_start) fs_a++;
  endtask

  task automatic go_a(input int k);
    while (ka < k) adv();
  endtask

  task automatic go_b(input int k);
    while (kb < k) adv();
  endtask

  task automatic clear_tally();
    ka = 0; kb = 0;
    rdy_a = 0; rdy_b = 0; isl_a = 0; isl_b = 0; fs_a = 0;
  endtask

  initial begin
    // Reset values, then a packet-free frame on A
    ra = 1'b1; rb = 1'b1;
    ia.packet_valid = 1'b0; ib.packet_valid = 1'b0;
    repeat (2) @(negedge clk_pixel);
    chk("rst_cx", ia.cx, 0);
    chk("rst_cy", ia.cy, 0);
    chk("rst_mode", ia.mode, 0);
    chk("rst_ctl0", ia.ctl0, 0);
    chk("rst_ctl1", ia.ctl1, 0);
    chk("rst_ctl2", ia.ctl2, 0);
    chk("rst_ready", ia.packet_ready, 0);
    chk("rst_di_index", ia.di_index, 0);
    chk("rst_di_first", ia.di_first, 0);
    chk("rst_frame_start", ia.frame_start, 0);
    chk("rst_b_mode", ib.mode, 0);
    ra = 1'b0;
    clear_tally();

    go_a(1);    chk("p1_mode_x1", ia.mode, 1);
    go_a(10);   chk("p1_mode_x10", ia.mode, 1); chk("p1_cx10", ia.cx, 10);
    go_a(64);   chk("p1_mode_x64", ia.mode, 0);
    go_a(71);   chk("p1_hs_x71", ia.ctl0, 0);
    go_a(72);   chk("p1_hs_x72", ia.ctl0, 1);
    go_a(87);   chk("p1_hs_x87", ia.ctl0, 1);
    go_a(88);   chk("p1_hs_x88", ia.ctl0, 0);
    go_a(134);  chk("p1_vpre_mode", ia.mode, 0); chk("p1_vpre_ctl1", ia.ctl1, 1); chk("p1_vpre_ctl2", ia.ctl2, 0);
    go_a(141);  chk("p1_vpre_ctl1_141", ia.ctl1, 1);
    go_a(142);  chk("p1_vguard_142", ia.mode, 2);
    go_a(143);  chk("p1_vguard_143", ia.mode, 2);
    go_a(495);  chk("p1_mode_63_3", ia.mode, 1); chk("p1_cy3", ia.cy, 3);
    go_a(566);  chk("p1_nopre_y3", ia.ctl1, 0);
    go_a(574);  chk("p1_noguard_y3", ia.mode, 0);
    go_a(586);  chk("p1_blank_y4", ia.mode, 0);
    go_a(730);  chk("p1_vs_only", ia.ctl0, 2);
    go_a(800);  chk("p1_vs_hs", ia.ctl0, 3);
    go_a(1006); chk("p1_noguard_y6", ia.mode, 0);
    go_a(1142); chk("p1_vpre_y7", ia.ctl1, 1);
    go_a(1150); chk("p1_vguard_y7", ia.mode, 2);
    go_a(1152); chk("p1_wrap_cx", ia.cx, 0); chk("p1_wrap_cy", ia.cy, 0);
                chk("p1_wrap_fs", ia.frame_start, 1); chk("p1_wrap_mode", ia.mode, 1);
    go_a(1153); chk("p1_fs_drop", ia.frame_start, 0);
    chk("p1_fs_count", fs_a, 1);
    chk("p1_no_island", isl_a, 0);
    chk("p1_no_ready", rdy_a, 0);

    // Constant packet_valid on both A (cap 1) and B (cap 2)
    ra = 1'b1; rb = 1'b1;
    @(negedge clk_pixel);
    ia.packet_valid = 1'b1; ib.packet_valid = 1'b1;
    ra = 1'b0; rb = 1'b0;
    clear_tally();
    go_a(67);  chk("p2_a67_mode", ia.mode, 0); chk("p2_a67_ctl1", ia.ctl1, 0);
    go_a(68);  chk("p2_a68_ctl1", ia.ctl1, ISL ? 1 : 0); chk("p2_a68_ctl2", ia.ctl2, ISL ? 1 : 0);
               chk("p2_a68_mode", ia.mode, 0); chk("p2_b68_ctl2", ib.ctl2, ISL ? 1 : 0);
    go_a(75);  chk("p2_a75_ctl2", ia.ctl2, ISL ? 1 : 0);
    go_a(76);  chk("p2_a76_mode", ia.mode, ISL ? 4 : 0);
    go_a(77);  chk("p2_a77_mode", ia.mode, ISL ? 4 : 0);
    go_a(78);  chk("p2_a78_mode", ia.mode, ISL ? 3 : 0); chk("p2_a78_ready", ia.packet_ready, ISL ? 1 : 0);
               chk("p2_a78_index", ia.di_index, 0); chk("p2_a78_first", ia.di_first, ISL ? 1 : 0);
               chk("p2_b78_ready", ib.packet_ready, ISL ? 1 : 0);
    go_a(79);  chk("p2_a79_ready", ia.packet_ready, 0); chk("p2_a79_index", ia.di_index, ISL ? 1 : 0);
               chk("p2_a79_first", ia.di_first, 0);
    go_a(109); chk("p2_a109_index", ia.di_index, ISL ? 31 : 0); chk("p2_b109_index", ib.di_index, ISL ? 31 : 0);
    go_a(110); chk("p2_a110_mode", ia.mode, ISL ? 4 : 0); chk("p2_b110_mode", ib.mode, ISL ? 3 : 0);
               chk("p2_b110_ready", ib.packet_ready, ISL ? 1 : 0); chk("p2_b110_first", ib.di_first, 0);
    go_a(111); chk("p2_a111_mode", ia.mode, ISL ? 4 : 0);
    go_a(112); chk("p2_a112_mode", ia.mode, 0); chk("p2_a112_ready", ia.packet_ready, 0);
    go_a(141); chk("p2_b141_index", ib.di_index, ISL ? 31 : 0);
    go_a(142); chk("p2_b142_mode", ib.mode, ISL ? 4 : 0); chk("p2_a142_mode", ia.mode, 2);
    go_a(143); chk("p2_b143_mode", ib.mode, ISL ? 4 : 0);
    go_a(144); chk("p2_b144_mode", ib.mode, 0); chk("p2_b144_cx", ib.cx, 144);
    go_a(1152);
    chk("p2_a_ready_count", rdy_a, ISL ? 8 : 0);
    chk("p2_b_ready_count", rdy_b, ISL ? 12 : 0);
    chk("p2_a_island_pixels", isl_a, ISL ? 288 : 0);
    chk("p2_b_island_pixels", isl_b, ISL ? 377 : 0);

    // B drops packet_valid after its first grant; A is reset mid-packet
    ra = 1'b1; rb = 1'b1;
    @(negedge clk_pixel);
    ra = 1'b0; rb = 1'b0;
    clear_tally();
    go_a(78);  chk("p3_b78_ready", ib.packet_ready, ISL ? 1 : 0);
    ib.packet_valid = 1'b0;
    go_a(90);  chk("p3_a90_mode", ia.mode, ISL ? 3 : 0); chk("p3_a90_index", ia.di_index, ISL ? 12 : 0);
    ra = 1'b1;
    #1;
    chk("p3_async_cx", ia.cx, 0); chk("p3_async_cy", ia.cy, 0);
    chk("p3_async_mode", ia.mode, 0); chk("p3_async_ready", ia.packet_ready, 0);
    chk("p3_async_index", ia.di_index, 0); chk("p3_async_ctl0", ia.ctl0, 0);
    chk("p3_async_ctl1", ia.ctl1, 0);
    repeat (3) adv();
    chk("p3_held_cx", ia.cx, 0); chk("p3_held_ready", ia.packet_ready, 0);
    ra = 1'b0;
    ka = 0;
    chk("p3_rel_cx", ia.cx, 0); chk("p3_rel_cy", ia.cy, 0); chk("p3_rel_fs", ia.frame_start, 0);
    go_a(1);   chk("p3_a1_cx", ia.cx, 1); chk("p3_a1_mode", ia.mode, 1); chk("p3_a1_fs", ia.frame_start, 0);
    go_b(109); chk("p3_b109_index", ib.di_index, ISL ? 31 : 0);
    go_b(110); chk("p3_b110_mode", ib.mode, ISL ? 4 : 0); chk("p3_b110_ready", ib.packet_ready, 0);
    go_b(111); chk("p3_b111_mode", ib.mode, ISL ? 4 : 0);
    go_b(112); chk("p3_b112_mode", ib.mode, 0);
    go_a(78);  chk("p3_a78_ready", ia.packet_ready, ISL ? 1 : 0); chk("p3_a78_mode", ia.mode, ISL ? 3 : 0);
    go_a(110); chk("p3_a110_mode", ia.mode, ISL ? 4 : 0);
    chk("p3_b_ready_count", rdy_b, ISL ? 1 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hdmi_period_scheduler.md
# hdmi_period_scheduler

Generates raster timing for the HDMI transmitter and drives the per-pixel period sequence (control, video preamble, video guard band, active video, data-island preamble, island guard bands, island packets) for the three TMDS channel encoders. It sits between the pixel/packet sources and the three channel encoders. It hands out data-island slots to the packet source through a valid/ready handshake.

## Interface
- H_ACTIVE, 1920, active pixels per line
- H_FRONT, 88 / H_SYNC, 44 / H_BACK, 148, horizontal blanking segments in pixels
- V_ACTIVE, 1080 / V_FRONT, 4 / V_SYNC, 5 / V_BACK, 36, vertical segments in lines
- HSYNC_POL, 1 / VSYNC_POL, 1, asserted sync level
- MAX_PACKETS, 2, island packets per line cap (1..18)
- clk_pixel  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- packet_valid  in  1  packet source has a 32-pixel packet pending
- packet_ready  out  1  one-cycle pulse on first pixel of a granted packet (consume)
- cx  out  12  horizontal position; cy  out  11  vertical position
- mode  out  3  0 control, 1 video, 2 video guard, 3 island, 4 island guard
- ctl0  out  2  {vsync, hsync}; ctl1, ctl2  out  2  preamble bits {CTL1,CTL0}, {CTL3,CTL2}
- di_index  out  5  pixel index within current packet (0..31)
- di_first  out  1  high on first island (mode 3) pixel of each island
- frame_start  out  1  high while cx=0, cy=0 after a wrap

## Operation
- Raster: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; cx wraps at H_TOTAL-1 → 0, incrementing cy; cy wraps at V_TOTAL-1 → 0.
- Sync: hsync asserted for cx in [H_ACTIVE+H_FRONT, +H_SYNC); vsync for cy in [V_ACTIVE+V_FRONT, +V_SYNC); ctl0 valid in every mode (TERC4 carries it during islands).
- Video: mode 1 when cx<H_ACTIVE and cy<V_ACTIVE. On lines preceding an active line (cy<V_ACTIVE-1 or cy=V_TOTAL-1): cx in [H_TOTAL-10, H_TOTAL-3] is video preamble, with ctl1=2'b01 and ctl2=2'b00; cx in [H_TOTAL-2, H_TOTAL-1] is mode 2.
- Island FSM states: IDLE, PREAMBLE(8), LEAD_GUARD(2), PACKET(32 each), TRAIL_GUARD(2).
  - IDLE→PREAMBLE at cx=DI_START=H_ACTIVE+4 if packet_valid is high and a one-packet island fits: DI_START+44 ≤ H_TOTAL-14.
  - PREAMBLE: ctl1=2'b01, ctl2=2'b01, mode 0.
  - LEAD_GUARD and TRAIL_GUARD: mode 4.
  - PACKET: mode 3; di_index counts 0..31; packet_ready pulses at di_index=0.
  - At di_index=31, the FSM continues with another packet if packet_valid is high, packets_this_line<MAX_PACKETS, and cx+1+34 ≤ H_TOTAL-14. Otherwise it goes to TRAIL_GUARD.
  - TRAIL_GUARD→IDLE.
- Outside preambles, ctl1=ctl2=0.
- Islands are allowed on every line, active or blanking.
- A packet is granted only by a packet_ready pulse. A packet_valid that drops during PREAMBLE or LEAD_GUARD does not cancel the island; the packet source must hold its packet until packet_ready.
- Elaboration error if MAX_PACKETS is out of range or a one-packet island does not fit.

## Timing
- All outputs are registered and mutually aligned: mode, ctl* and di_* describe the pixel at the cx and cy shown that cycle.
- The channel encoder adds one further register stage downstream.
- Reset state: cx=0, cy=0, mode=0, ctl0 = deasserted sync levels, ctl1=ctl2=0, packet_ready=0, di_index=0, di_first=0, frame_start=0, FSM IDLE, packet count 0.
- frame_start is 0 on the first cycle after reset. It pulses on each later wrap to (0,0).
- Reset asserted mid-island aborts the island immediately. No trailing guard is emitted and no packet_ready is issued.
- The packet counter clears at cx=0 each line.

## Configuration
- HDMI_DATA_ISLAND_EN defined: the island FSM and handshake operate as above.
- HDMI_DATA_ISLAND_EN undefined (DVI only): the FSM is not compiled. mode is never 3 or 4, packet_ready, di_index and di_first are tied 0, and only video preambles are emitted.

## Structure
- Package hdmi_sched_pkg holds:
  - mode encodings MODE_CTRL, MODE_VIDEO, MODE_VGUARD, MODE_ISLAND, MODE_IGUARD
  - preamble constants PRE_VIDEO and PRE_ISLAND
  - lengths PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32, MIN_CTRL_TAIL=14
  - the island FSM state typedef
- Sub-module hdmi_timing_counter produces cx, cy, sync and frame_start. The scheduler owns the FSM and output registers.

## Test plan
- Test parameters for all scenarios: H_ACTIVE=64, H_FRONT=8, H_SYNC=16, H_BACK=56 (H_TOTAL=144), V_ACTIVE=4, V_FRONT=1, V_SYNC=1, V_BACK=2 (V_TOTAL=8), MAX_PACKETS=1.
- packet_valid=0 for a full frame → mode 1 for cx 0..63 on cy 0..3. Preamble at cx 134..141 and guard at cx 142..143 on cy 0..2 and 7. No mode 3/4 anywhere. hsync asserted at cx 72..87. frame_start high once, at wrap.
- packet_valid=1 constant → per line: preamble cx 68..75 (ctl1=ctl2=01), mode 4 at cx 76..77, mode 3 at cx 78..109 with packet_ready at 78 only, mode 4 at cx 110..111, mode 0 after. Exactly one packet per line (cap).
- MAX_PACKETS=2 with H_BACK=120 (H_TOTAL=208), packet_valid=1 → two packets: packet_ready at cx 78 and 110, trailing guard cx 142..143.
- Same setup, packet_valid dropped after the first packet_ready → trailing guard at cx 110..111 and no second grant.
- reset asserted at cx=90 mid-packet, held for 3 cycles → outputs go to reset values asynchronously. The line restarts at cx=0, cy=0, and frame_start stays 0 on that cycle.
- Build without HDMI_DATA_ISLAND_EN, packet_valid=1 → packet_ready never asserts and mode stays in {0,1,2}.
